uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Upstream stage of the TX dispatcher: buffers command bytes from the host-side logic and serializes them as 8N1 UART frames onto one line.
- TX feeds the dispatcher's IN, which fans the line out to the 22 open-drain driver outputs.
- Idle line is high, so the dispatcher outputs float and its LED is off while idle.

Parameters:
- CLKS_PER_BIT, 104, CLK cycles per UART bit (12 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 8, byte FIFO entries; power of two, 2..64.
- LEVEL_W, $clog2(FIFO_DEPTH)+1, width of the LEVEL output.

Ports:
- CLK  input  1  system clock; sole clock domain.
- RST  input  1  synchronous, active-high reset.
- DATA  input  8  byte to transmit.
- VALID  input  1  DATA is valid this cycle.
- READY  output  1  FIFO can accept; a transfer occurs on a rising CLK edge when VALID && READY.
- TX  output  1  serial line to dispatcher IN; registered output.
- BUSY  output  1  high while a frame is on the line or the FIFO is non-empty.
- DONE  output  1  one-cycle pulse in the last cycle of each stop bit.
- LEVEL  output  LEVEL_W  current FIFO occupancy.

Behaviour:
- Clocking and reset: one clock (CLK). Reset is synchronous and active-high (RST).
- Reset values (at the first edge with RST=1): TX=1, READY=0 while RST is high, BUSY=0, DONE=0, LEVEL=0, FSM=IDLE, FIFO pointers=0, baud counter=0. READY=1 from the first cycle after RST deasserts.
- Reset mid-frame: the frame is aborted, TX returns to 1 at that edge, and the FIFO contents are discarded. No partial byte is resumed.
- READY = !full. Pushes while full are impossible by construction. DATA is ignored when VALID=0.
- Simultaneous push and pop: LEVEL is unchanged and both operations take effect. When full, a pop frees a slot only for the next cycle; READY is not combinationally dependent on pop.
- FIFO pointers wrap modulo FIFO_DEPTH. LEVEL ranges 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If LEVEL!=0, pop the head into shift register SR, load the baud counter with CLKS_PER_BIT-1, drive TX<=0, go to START.
  - START: hold TX=0 for CLKS_PER_BIT cycles. When the counter reaches 0, drive TX<=SR[0], set bit index=0, reload the counter, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. At counter 0: if index==7, drive TX<=1, reload, go to STOP; else shift SR right, increment index, drive TX<=next bit.
  - STOP: hold TX=1 for CLKS_PER_BIT cycles. At counter 0, pulse DONE. If the FIFO is non-empty, pop, drive TX<=0 and go directly to START (no idle gap); else go to IDLE.
- Latency: a byte accepted at edge k into an empty FIFO with FSM IDLE appears in the FIFO at edge k. The FSM pops at edge k+1, and TX falls at edge k+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- BUSY = (state!=IDLE) || (LEVEL!=0).
- TX never glitches: it is driven only from a flop.
- Baud counter: width $clog2(CLKS_PER_BIT); it counts down and never underflows.

Decomposition:
- Package uart_tx_pkg:
  - typedef enum for FSM states {IDLE, START, DATA, STOP};
  - localparam FRAME_BITS=10;
  - localparam DATA_BITS=8.
- Sub-module tx_byte_fifo (synchronous FIFO):
  - parameters DEPTH, WIDTH=8;
  - ports CLK, RST, push, din, pop, dout, full, empty, level;
  - dout shows the head combinationally (first-word fall-through).
- The FSM and baud counter stay in uart_tx_framer.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Reset, then idle 50 cycles -> TX=1, READY=1, BUSY=0, LEVEL=0, no DONE pulses.
- Push 0xA5 once at edge k -> TX low over edges k+1..k+4. Line then carries bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1. DONE pulses once at edge k+40. BUSY drops after that.
- Push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous 40-cycle frames with no idle cycle between them. Exactly three DONE pulses, 40 cycles apart.
- Hold VALID=1 with incrementing data for 20 cycles while transmitting -> READY drops when LEVEL=8. Accepted bytes are transmitted in order with no loss or duplication; the scoreboard compares the decoded line against accepted bytes.
- Assert RST for 1 cycle midway through DATA of frame 1 with 3 bytes queued -> TX=1 at that edge, LEVEL=0, BUSY=0. No further frames are sent, and a new push transmits correctly.
- Push on the same cycle as the STOP-end pop with LEVEL=8 -> READY stays 0 that cycle. LEVEL=7 on the next cycle, READY=1, and no byte is dropped.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX framer.
// States, frame geometry.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through head.
// Pointers wrap modulo DEPTH; level spans 0..DEPTH.
module tx_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             wr;
  logic             rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rptr];
  assign level = count;

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffers host bytes and serializes them as 8N1 frames on TX.
// TX is driven only from a flop; stop-end pops chain frames.
import uart_tx_pkg::*;

module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8,
  parameter int LEVEL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         DATA,
  input  logic               VALID,
  output logic               READY,
  output logic               TX,
  output logic               BUSY,
  output logic               DONE,
  output logic [LEVEL_W-1:0] LEVEL
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [7:0]    sr;
  logic [7:0]    sr_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic          tx_q;
  logic          tx_n;
  logic          pop;
  logic          full;
  logic          empty;
  logic          tick;
  logic [7:0]    head;

  tx_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (VALID && READY),
    .din   (DATA),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (LEVEL)
  );

  assign READY = !full && !RST;
  assign tick  = (cnt == '0);
  assign TX    = tx_q;
  assign DONE  = (state == STOP) && tick;
  assign BUSY  = (state != IDLE) || !empty;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      idx   <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sr    <= sr_n;
      idx   <= idx_n;
      tx_q  <= tx_n;
    end
  end

  // The port DATA hides the enum literal, so the state is pkg-qualified.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    idx_n   = idx;
    tx_n    = tx_q;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sr_n    = head;
          cnt_n   = RELOAD;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          tx_n    = sr[0];
          idx_n   = '0;
          cnt_n   = RELOAD;
          state_n = uart_tx_pkg::DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      uart_tx_pkg::DATA: begin
        if (tick) begin
          cnt_n = RELOAD;
          if (idx == 3'(DATA_BITS - 1)) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            sr_n  = sr >> 1;
            idx_n = idx + 3'd1;
            tx_n  = sr[1];
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            sr_n    = head;
            cnt_n   = RELOAD;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with a line decoder scoreboard.
// CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_framer;

  localparam int CPB = 4;
  localparam int DEP = 8;
  localparam int LW  = $clog2(DEP) + 1;

  logic          CLK;
  logic          RST;
  logic [7:0]    DATA;
  logic          VALID;
  logic          READY;
  logic          TX;
  logic          BUSY;
  logic          DONE;
  logic [LW-1:0] LEVEL;

  int checks = 0;
  int errors = 0;

  logic [7:0] acc_q[$];
  logic [7:0] dec_q[$];
  bit         infr = 1'b0;
  int         c = 0;
  logic [7:0] sh = '0;
  int         frame_err = 0;

  uart_tx_framer #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEP),
    .LEVEL_W      (LW)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DATA  (DATA),
    .VALID (VALID),
    .READY (READY),
    .TX    (TX),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .LEVEL (LEVEL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Bytes the DUT will accept at the coming edge.
  always @(negedge CLK) begin
    if (!RST && VALID && READY) acc_q.push_back(DATA);
  end

  // Line decoder: c is the cycle index within the frame.
  always @(negedge CLK) begin
    if (RST) begin
      infr <= 1'b0;
    end else if (!infr) begin
      if (TX === 1'b0) begin
        infr <= 1'b1;
        c    <= 1;
      end
    end else begin
      c <= c + 1;
      if (c >= 6 && c <= 34 && (c % 4) == 2)
        sh <= {TX, sh[7:1]};
      if (c == 38 && TX !== 1'b1)
        frame_err <= frame_err + 1;
      if (c == 39) begin
        dec_q.push_back(sh);
        infr <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_frame(input logic [7:0] b);
    logic e;
    int   k;
    for (int i = 0; i < 10 * CPB; i++) begin
      step();
      k = i / CPB;
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      chk("frame_tx", TX, e);
      chk("frame_done", DONE, (i == 10 * CPB - 1));
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (BUSY && n < lim) begin
      step();
      n++;
    end
    chk("drain_bound", (n < lim), 1);
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, dec_q.size(), acc_q.size());
    for (int i = 0; i < acc_q.size() && i < dec_q.size(); i++)
      chk(tag, dec_q[i], acc_q[i]);
    chk({tag, "_stop"}, frame_err, 0);
  endtask

  initial begin
    logic [7:0] exp3 [4];
    exp3 = '{8'hA5, 8'h00, 8'hFF, 8'h55};
    RST   = 1'b1;
    VALID = 1'b0;
    DATA  = 8'h00;
    step();
    step();
    chk("rst_tx", TX, 1);
    chk("rst_ready", READY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_level", LEVEL, 0);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", READY, 1);

    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_tx", TX, 1);
      chk("idle_done", DONE, 0);
    end
    chk("idle_ready", READY, 1);
    chk("idle_busy", BUSY, 0);
    chk("idle_level", LEVEL, 0);

    VALID = 1'b1;
    DATA  = 8'hA5;
    step();
    VALID = 1'b0;
    chk("a5_level", LEVEL, 1);
    chk("a5_tx_pre", TX, 1);
    chk("a5_busy", BUSY, 1);
    expect_frame(8'hA5);
    step();
    chk("a5_busy_end", BUSY, 0);
    chk("a5_done_end", DONE, 0);
    chk("a5_tx_end", TX, 1);
    chk("a5_level_end", LEVEL, 0);

    VALID = 1'b1;
    DATA  = 8'h00;
    step();
    fork
      begin
        DATA = 8'hFF;
        step();
        DATA = 8'h55;
        step();
        VALID = 1'b0;
      end
      begin
        expect_frame(8'h00);
        expect_frame(8'hFF);
        expect_frame(8'h55);
      end
    join
    step();
    chk("b2b_busy_end", BUSY, 0);
    chk("b2b_dec_n", dec_q.size(), 4);
    for (int i = 0; i < 4 && i < dec_q.size(); i++)
      chk("b2b_dec_val", dec_q[i], exp3[i]);
    cmp_q("b2b_sb");
    acc_q.delete();
    dec_q.delete();

    for (int i = 0; i < 20; i++) begin
      VALID = 1'b1;
      DATA  = 8'h10 + 8'(i);
      step();
      if (i == 7) begin
        chk("fill_level7", LEVEL, 7);
        chk("fill_ready7", READY, 1);
      end
      if (i == 8) begin
        chk("fill_level8", LEVEL, 8);
        chk("fill_ready8", READY, 0);
      end
    end
    VALID = 1'b0;
    chk("fill_level_hold", LEVEL, 8);
    wait_idle(600);
    chk("fill_acc_n", acc_q.size(), 9);
    if (dec_q.size() == 9) chk("fill_last", dec_q[8], 8'h18);
    cmp_q("fill_sb");
    acc_q.delete();
    dec_q.delete();

    for (int i = 0; i < 4; i++) begin
      VALID = 1'b1;
      DATA  = 8'h31 + 8'(i);
      step();
    end
    VALID = 1'b0;
    chk("abort_level3", LEVEL, 3);
    repeat (15) step();
    RST = 1'b1;
    step();
    chk("abort_tx", TX, 1);
    chk("abort_level", LEVEL, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_ready_rst", READY, 0);
    RST = 1'b0;
    #1;
    chk("abort_ready", READY, 1);
    for (int i = 0; i < 60; i++) begin
      step();
      chk("abort_quiet_tx", TX, 1);
    end
    chk("abort_no_frames", dec_q.size(), 0);
    acc_q.delete();
    dec_q.delete();
    VALID = 1'b1;
    DATA  = 8'h5A;
    step();
    VALID = 1'b0;
    expect_frame(8'h5A);
    step();
    chk("after_abort_busy", BUSY, 0);
    cmp_q("after_abort_sb");
    acc_q.delete();
    dec_q.delete();

    for (int i = 0; i < 9; i++) begin
      VALID = 1'b1;
      DATA  = 8'h80 + 8'(i);
      step();
    end
    DATA = 8'hE0;
    chk("pp_full_level", LEVEL, 8);
    chk("pp_full_ready", READY, 0);
    repeat (32) step();
    chk("pp_stop_done", DONE, 1);
    chk("pp_stop_level", LEVEL, 8);
    chk("pp_stop_ready", READY, 0);
    step();
    chk("pp_pop_level", LEVEL, 7);
    chk("pp_pop_ready", READY, 1);
    chk("pp_pop_done", DONE, 0);
    step();
    VALID = 1'b0;
    chk("pp_refill_level", LEVEL, 8);
    wait_idle(600);
    chk("pp_acc_n", acc_q.size(), 10);
    if (acc_q.size() == 10) chk("pp_acc_last", acc_q[9], 8'hE0);
    cmp_q("pp_sb");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
